// File: rtl/hmlf_min_sched_pkg.sv
// Shared constants and state encoding for the windowed signed-minimum scheduler.
package hmlf_min_sched_pkg;

  localparam int HMLF_W   = 6;
  localparam int HMLF_WIN = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } hmlf_state_e;

endpackage

// File: rtl/hmlf_min2.sv
// Combinational signed 2-input minimum; b wins only when strictly less than a.
module hmlf_min2 #(
  parameter int W = 6
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] min,
  output logic                b_lt_a
);

  assign b_lt_a = (b < a);
  assign min    = b_lt_a ? b : a;

endmodule

// File: rtl/hmlf_min_sched.sv
// Collects WIN signed samples, reports the minimum and its first position, then holds
// the result until downstream takes it.
module hmlf_min_sched
  import hmlf_min_sched_pkg::*;
#(
  parameter int W   = HMLF_W,
  parameter int WIN = HMLF_WIN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic signed [W-1:0]        in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [W-1:0]        out_min,
  output logic [$clog2(WIN)-1:0]     out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output hmlf_state_e                state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and a held result stays stable until it transfers.

  localparam int CW = $clog2(WIN + 1);
  localparam int IW = $clog2(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);

  hmlf_state_e         state, state_next;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] run_min;
  logic [IW-1:0]       run_idx;
  logic signed [W-1:0] cmp_min;
  logic                cmp_lt;
  logic                take;

  hmlf_min2 #(.W(W)) u_min2 (
    .a      (run_min),
    .b      (in_data),
    .min    (cmp_min),
    .b_lt_a (cmp_lt)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_ACC;
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // Abort wins over any concurrent sample or result handshake.
    if (clr) state_next = ST_IDLE;
  end

  assign take = in_valid & in_ready & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_min <= '0;
      run_idx <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (take) begin
      if (state == ST_IDLE) begin
        run_min <= in_data;
        run_idx <= '0;
        cnt     <= CW'(1);
      end else begin
        // The count equals the position of the incoming sample within the window.
        if (cmp_lt) begin
          run_min <= cmp_min;
          run_idx <= cnt[IW-1:0];
        end
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  assign out_min   = run_min;
  assign out_idx   = run_idx;
  assign state_dbg = state;

endmodule

// File: tb/tb_hmlf_min_sched.sv
// Bench for hmlf_min_sched: directed windows plus randomized gapped traffic against a
// window-level reference model.
module tb_hmlf_min_sched;
  import hmlf_min_sched_pkg::*;

  localparam int W   = 6;
  localparam int WIN = 8;
  localparam int IW  = $clog2(WIN);

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr = 1'b0;
  logic signed [W-1:0] in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] out_min;
  logic [IW-1:0]       out_idx;
  logic                out_valid;
  logic                out_ready = 1'b0;
  hmlf_state_e         state_dbg;

  int checks = 0;
  int passes = 0;

  logic signed [W-1:0] win_q[$];
  logic [W+IW-1:0]     exp_q[$];

  hmlf_min_sched #(.W(W), .WIN(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference: smallest value of the window, located at its first occurrence.
  function automatic void model_close();
    logic signed [W-1:0] m;
    int idx;
    m = win_q[0];
    foreach (win_q[i]) if (win_q[i] < m) m = win_q[i];
    idx = 0;
    for (int i = WIN - 1; i >= 0; i--) if (win_q[i] == m) idx = i;
    exp_q.push_back({m, IW'(idx)});
    win_q.delete();
  endfunction

  // Presents one sample and returns just after the edge that accepts it.
  task automatic drive_sample(input logic [W-1:0] d);
    int n;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    win_q.push_back(d);
    if (win_q.size() == WIN) model_close();
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic ack_result();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %0b required 0", out_valid); else passes++;
    checks++; if (out_min !== '0) $display("FAIL rst_out_min got %0d required 0", out_min); else passes++;
    checks++; if (out_idx !== '0) $display("FAIL rst_out_idx got %0d required 0", out_idx); else passes++;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL rst_state got %0d required %0d", state_dbg, ST_IDLE); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %0b required 1", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_rel_out_valid got %0b required 0", out_valid); else passes++;
  endtask

  task automatic test_basic();
    int s[WIN] = '{5, 3, 7, -2, 0, 9, -1, 4};
    logic [W+IW-1:0] e;
    for (int i = 0; i < WIN - 1; i++) drive_sample(W'(s[i]));
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b required 0", out_valid); else passes++;
    drive_sample(W'(s[WIN-1]));
    #1;
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency got out_valid=%0b required 1", out_valid); else passes++;
    checks++; if (out_min !== W'(-2)) $display("FAIL basic_min got %0d required -2", out_min); else passes++;
    checks++; if (out_idx !== IW'(3)) $display("FAIL basic_idx got %0d required 3", out_idx); else passes++;
    checks++; if ({out_min, out_idx} !== e) $display("FAIL basic_model got %0h required %0h", {out_min, out_idx}, e); else passes++;
    ack_result();
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL basic_ack_state got %0d required %0d", state_dbg, ST_IDLE); else passes++;
  endtask

  task automatic test_ties();
    int s[WIN] = '{31, -32, 10, -32, 0, 0, 0, -32};
    logic [W+IW-1:0] e;
    for (int i = 0; i < WIN; i++) drive_sample(W'(s[i]));
    #1;
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1) $display("FAIL ties_valid got %0b required 1", out_valid); else passes++;
    checks++; if (out_min !== W'(-32)) $display("FAIL ties_min got %0d required -32", out_min); else passes++;
    checks++; if (out_idx !== IW'(1)) $display("FAIL ties_idx got %0d required 1", out_idx); else passes++;
    checks++; if ({out_min, out_idx} !== e) $display("FAIL ties_model got %0h required %0h", {out_min, out_idx}, e); else passes++;
    ack_result();
  endtask

  task automatic test_backpressure();
    logic [W+IW-1:0] e;
    for (int i = 0; i < WIN; i++) drive_sample(W'($urandom_range(0, (1 << W) - 1)));
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = W'($urandom_range(0, (1 << W) - 1));
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cyc %0d got %0b required 0", c, in_ready); else passes++;
      checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cyc %0d got %0b required 1", c, out_valid); else passes++;
      checks++; if ({out_min, out_idx} !== e) $display("FAIL bp_stable cyc %0d got %0h required %0h", c, {out_min, out_idx}, e); else passes++;
    end
    ack_result();
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL bp_release_state got %0d required %0d", state_dbg, ST_IDLE); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b required 1", in_ready); else passes++;
    for (int i = 0; i < WIN; i++) drive_sample(W'($urandom_range(0, (1 << W) - 1)));
    #1;
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_min, out_idx} !== e)
      $display("FAIL bp_next_window got v=%0b %0h required v=1 %0h", out_valid, {out_min, out_idx}, e); else passes++;
    ack_result();
  endtask

  task automatic test_clr();
    logic [W+IW-1:0] e;
    drive_sample(W'(-32));
    for (int i = 1; i < 4; i++) drive_sample(W'($urandom_range(0, 31)));
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(-32);
    @(posedge clk);
    #1;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL clr_state got %0d required %0d", state_dbg, ST_IDLE); else passes++;
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    win_q.delete();
    for (int i = 0; i < WIN; i++) drive_sample(W'($urandom_range(0, 31)));
    #1;
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_min, out_idx} !== e)
      $display("FAIL clr_fresh got v=%0b %0h required v=1 %0h", out_valid, {out_min, out_idx}, e); else passes++;
    @(negedge clk);
    in_valid  = 1'b0;
    clr       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    clr       = 1'b0;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("FAIL clr_hold_valid got %0b required 0", out_valid); else passes++;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL clr_hold_state got %0d required %0d", state_dbg, ST_IDLE); else passes++;
  endtask

  task automatic test_gapped_reset();
    logic [W+IW-1:0] e;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < WIN; i++) begin
        drive_idle($urandom_range(0, 3));
        drive_sample(W'($urandom_range(0, (1 << W) - 1)));
      end
      #1;
      e = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || {out_min, out_idx} !== e)
        $display("FAIL gap_window %0d got v=%0b %0h required v=1 %0h", w, out_valid, {out_min, out_idx}, e); else passes++;
      drive_idle($urandom_range(0, 3));
      ack_result();
    end
    for (int i = 0; i < 3; i++) drive_sample(W'($urandom_range(0, (1 << W) - 1)));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks++; if (state_dbg !== ST_IDLE || out_min !== '0) $display("FAIL midrst_state got st=%0d min=%0d required st=0 min=0", state_dbg, out_min); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    win_q.delete();
    for (int i = 0; i < WIN - 3; i++) begin
      drive_idle($urandom_range(0, 2));
      drive_sample(W'($urandom_range(0, (1 << W) - 1)));
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_no_valid after %0d got %0b required 0", i + 1, out_valid); else passes++;
    end
    for (int i = 0; i < 3; i++) drive_sample(W'($urandom_range(0, (1 << W) - 1)));
    #1;
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_min, out_idx} !== e)
      $display("FAIL midrst_window got v=%0b %0h required v=1 %0h", out_valid, {out_min, out_idx}, e); else passes++;
    ack_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_clr();
    test_gapped_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
